// File: rtl/gpu_pixel_fetch.sv
// gpu_pixel_fetch: issues halfword reads for pixel addresses and returns pixels in order,
// with a credit counter so returned data can never overflow the response buffer.
module gpu_pixel_fetch #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              re_valid,
   output logic              re_ready,
   input  logic [ADDR_W-1:0] re_memory_address,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_address,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rsp_data,
   output logic              se_valid,
   input  logic              se_ready,
   output logic [DATA_W-1:0] se_pixel,
   output logic              busy,
   output logic [1:0]        err
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   logic              rst_q;
   logic [CW-1:0]     in_use, outstanding, count;
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [DATA_W-1:0] fifo [DEPTH];
   logic              re_hs, mem_hs, se_hs, rsp_ok, rsp_bad;
   assign re_hs    = re_valid && re_ready;
   assign mem_hs   = mem_req_valid && mem_req_ready;
   assign se_hs    = se_valid && se_ready;
   assign rsp_bad  = mem_rsp_valid && (outstanding == '0);
   assign rsp_ok   = mem_rsp_valid && !rsp_bad;
   // a held request may be replaced in the same cycle it handshakes
   assign re_ready = !rst_q && (in_use < CW'(DEPTH)) && (!mem_req_valid || mem_req_ready);
   assign se_valid = count != '0;
   assign se_pixel = fifo[rd_ptr];
   assign busy     = (in_use != '0) || mem_req_valid;
   always_ff @(posedge clk) begin
      rst_q <= rst;
      if (rst) begin
         in_use          <= '0;
         outstanding     <= '0;
         count           <= '0;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         mem_req_valid   <= 1'b0;
         mem_req_address <= '0;
         err             <= '0;
      end else begin
         in_use        <= in_use + CW'(re_hs) - CW'(se_hs);
         outstanding   <= outstanding + CW'(mem_hs) - CW'(rsp_ok);
         count         <= count + CW'(rsp_ok) - CW'(se_hs);
         wr_ptr        <= wr_ptr + PW'(rsp_ok);
         rd_ptr        <= rd_ptr + PW'(se_hs);
         mem_req_valid <= re_hs || (mem_req_valid && !mem_hs);
         if (re_hs) mem_req_address <= {re_memory_address[ADDR_W-1:1], 1'b0};
         err           <= err | {re_hs && re_memory_address[0], rsp_bad};
      end
   end
   always_ff @(posedge clk) if (rsp_ok) fifo[wr_ptr] <= mem_rsp_data;
endmodule
